// File: rtl/led_display_pkg.sv
// ---------------------------------------------------------------------------
// led_display_pkg
// Purpose : Shared constants and types for the LED-display poller. This
//           covers the digit and key register counts, the slave address
//           offset of digit 0, the AXI burst and response encodings, and the
//           poller FSM state enum.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package led_display_pkg;

  localparam int DIGIT_COUNT = 32;
  localparam int KEY_COUNT   = 6;

  // Word offset of digit 0 relative to the configured base address.
  localparam logic [31:0] DIGIT_OFFSET = 32'd0;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_COMMIT,
    ST_WAIT
  } poll_state_t;

endpackage

// File: rtl/led_display_poller_if.sv
// ---------------------------------------------------------------------------
// led_display_poller_if
// Purpose : AXI read-channel bundle (AR + R) between the poller (master) and
//           the interconnect or capture slave (slave).
// Signals : AR  - MASTER_RD_ADDR_ID/ADDR/LEN/BURST/VALID/READY
//           R   - MASTER_RD_BACK_ID, MASTER_RD_DATA, MASTER_RD_DATA_RESP,
//                 MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID,
//                 MASTER_RD_DATA_READY
// ---------------------------------------------------------------------------
interface led_display_poller_if;

  logic [3:0]  MASTER_RD_ADDR_ID;
  logic [31:0] MASTER_RD_ADDR;
  logic [7:0]  MASTER_RD_ADDR_LEN;
  logic [1:0]  MASTER_RD_ADDR_BURST;
  logic        MASTER_RD_ADDR_VALID;
  logic        MASTER_RD_ADDR_READY;
  logic [3:0]  MASTER_RD_BACK_ID;
  logic [31:0] MASTER_RD_DATA;
  logic [1:0]  MASTER_RD_DATA_RESP;
  logic        MASTER_RD_DATA_LAST;
  logic        MASTER_RD_DATA_VALID;
  logic        MASTER_RD_DATA_READY;

  modport master (
    output MASTER_RD_ADDR_ID, MASTER_RD_ADDR, MASTER_RD_ADDR_LEN,
           MASTER_RD_ADDR_BURST, MASTER_RD_ADDR_VALID, MASTER_RD_DATA_READY,
    input  MASTER_RD_ADDR_READY, MASTER_RD_BACK_ID, MASTER_RD_DATA,
           MASTER_RD_DATA_RESP, MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID
  );

  modport slave (
    input  MASTER_RD_ADDR_ID, MASTER_RD_ADDR, MASTER_RD_ADDR_LEN,
           MASTER_RD_ADDR_BURST, MASTER_RD_ADDR_VALID, MASTER_RD_DATA_READY,
    output MASTER_RD_ADDR_READY, MASTER_RD_BACK_ID, MASTER_RD_DATA,
           MASTER_RD_DATA_RESP, MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID
  );

endinterface

// File: rtl/led_frame_buffer.sv
// ---------------------------------------------------------------------------
// led_frame_buffer
// Purpose : Double buffer for the 32 digit segment bytes. Beats land in
//           shadow as they arrive. A commit copies the whole shadow into snap
//           in one edge, so readers never see a mix of two frames.
// Ports   : clk, rst      - clock, async active-high reset (clears both)
//           wr_en/idx/data - shadow write from the current beat
//           commit         - copy shadow -> snap
//           rd_addr/rd_data- combinational read of snap
//           differs        - shadow and snap currently disagree
// ---------------------------------------------------------------------------
module led_frame_buffer
  import led_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       differs
);

  logic [7:0] shadow [DIGIT_COUNT];
  logic [7:0] snap   [DIGIT_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGIT_COUNT; i++) begin
        shadow[i] <= 8'h00;
        snap[i]   <= 8'h00;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_idx] <= wr_data;
      end
      if (commit) begin
        for (int i = 0; i < DIGIT_COUNT; i++) begin
          snap[i] <= shadow[i];
        end
      end
    end
  end

  // Evaluated while the FSM sits in COMMIT. No beat writes shadow then, so
  // the comparison reflects exactly the frame about to be committed.
  always_comb begin
    differs = 1'b0;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (shadow[i] != snap[i]) begin
        differs = 1'b1;
      end
    end
  end

  assign rd_data = snap[rd_addr];

endmodule

// File: rtl/led_display_poller.sv
// ---------------------------------------------------------------------------
// led_display_poller
// Purpose : AXI read master that periodically bursts the 32 digit registers
//           of the LED-display capture slave. It validates every beat and
//           commits only clean frames into a snapshot that the status logic
//           reads at random.
// Ports   : clk, rst            - clock, async active-high reset
//           poll_en             - allow new frames (sampled in IDLE)
//           axi                 - AXI read master (AR + R channels)
//           snap_addr/snap_data - combinational snapshot read port
//           frame_done          - 1-cycle pulse after a clean commit
//           frame_changed       - valid with frame_done; frame differed
//           frame_err           - sticky bad-frame flag
//           key_state           - committed key bits (key capture only)
// Config  : LED_DISPLAY_POLLER_KEY_EN - extends the burst by 6 key beats and
//           adds the key_state output.
// ---------------------------------------------------------------------------
module led_display_poller
  import led_display_pkg::*;
#(
  parameter int          POLL_INTERVAL = 50000,
  parameter logic [3:0]  AXI_ID        = 4'd0,
  parameter logic [31:0] BASE_ADDR     = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 poll_en,
  led_display_poller_if.master axi,
  input  logic [4:0]           snap_addr,
  output logic [7:0]           snap_data,
  output logic                 frame_done,
  output logic                 frame_changed,
`ifdef LED_DISPLAY_POLLER_KEY_EN
  output logic [5:0]           key_state,
`endif
  output logic                 frame_err
);

`ifdef LED_DISPLAY_POLLER_KEY_EN
  localparam logic [5:0] LAST_BEAT = 6'(DIGIT_COUNT + KEY_COUNT - 1);
`else
  localparam logic [5:0] LAST_BEAT = 6'(DIGIT_COUNT - 1);
`endif

  poll_state_t state;
  logic        ar_valid_q;
  logic        r_ready_q;
  logic [5:0]  beat_cnt;
  logic        frame_bad;
  logic [31:0] wait_cnt;

  logic        beat_fire;
  logic        is_digit;
  logic        beat_err;
  logic        shadow_we;
  logic        commit;
  logic        differs;
  logic        unused_bits;

  assign axi.MASTER_RD_ADDR_ID    = AXI_ID;
  assign axi.MASTER_RD_ADDR       = BASE_ADDR + DIGIT_OFFSET;
  assign axi.MASTER_RD_ADDR_LEN   = {2'b00, LAST_BEAT};
  assign axi.MASTER_RD_ADDR_BURST = AXI_BURST_INCR;
  assign axi.MASTER_RD_ADDR_VALID = ar_valid_q;
  assign axi.MASTER_RD_DATA_READY = r_ready_q;

  assign unused_bits = ^axi.MASTER_RD_DATA[31:16];

  assign beat_fire = (state == ST_DATA) && axi.MASTER_RD_DATA_VALID && r_ready_q;
  assign is_digit  = beat_cnt < 6'(DIGIT_COUNT);

  // A beat is bad for any of four reasons: the response is not OKAY, the ID
  // is foreign, a digit beat carries the wrong index, or LAST disagrees with
  // our own count (early, missing, or the slave ran past the burst).
  assign beat_err = (axi.MASTER_RD_DATA_RESP != AXI_RESP_OKAY)
                 || (axi.MASTER_RD_BACK_ID != AXI_ID)
                 || (is_digit && (axi.MASTER_RD_DATA[15:8] != {2'b00, beat_cnt}))
                 || (axi.MASTER_RD_DATA_LAST != (beat_cnt == LAST_BEAT))
                 || (beat_cnt > LAST_BEAT);

  assign shadow_we = beat_fire && is_digit;
  assign commit    = (state == ST_COMMIT) && !frame_bad;

  led_frame_buffer u_frame_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shadow_we),
    .wr_idx  (beat_cnt[4:0]),
    .wr_data (axi.MASTER_RD_DATA[7:0]),
    .commit  (commit),
    .rd_addr (snap_addr),
    .rd_data (snap_data),
    .differs (differs)
  );

`ifdef LED_DISPLAY_POLLER_KEY_EN
  logic [5:0] key_shadow;
  logic [5:0] key_idx;

  assign key_idx = beat_cnt - 6'(DIGIT_COUNT);

  // Key beats follow the digits. Only bit 0 matters, and the bits are held
  // back until the frame commits, just like the digit bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_shadow <= 6'd0;
      key_state  <= 6'd0;
    end else begin
      if (beat_fire && !is_digit && (beat_cnt <= LAST_BEAT)) begin
        key_shadow[key_idx[2:0]] <= axi.MASTER_RD_DATA[0];
      end
      if (commit) begin
        key_state <= key_shadow;
      end
    end
  end
`endif

  // Frame sequencer: IDLE -> ADDR -> DATA -> COMMIT -> WAIT -> IDLE.
  // Once AR is accepted, the burst always drains, whatever poll_en does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ar_valid_q    <= 1'b0;
      r_ready_q     <= 1'b0;
      beat_cnt      <= 6'd0;
      frame_bad     <= 1'b0;
      wait_cnt      <= 32'd0;
      frame_done    <= 1'b0;
      frame_changed <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_changed <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (poll_en) begin
            ar_valid_q <= 1'b1;
            state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ar_valid_q && axi.MASTER_RD_ADDR_READY) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            beat_cnt   <= 6'd0;
            frame_bad  <= 1'b0;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            if (beat_cnt != 6'h3F) begin
              beat_cnt <= beat_cnt + 6'd1;
            end
            if (beat_err) begin
              frame_bad <= 1'b1;
            end
            if (axi.MASTER_RD_DATA_LAST) begin
              r_ready_q <= 1'b0;
              state     <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          if (!frame_bad) begin
            frame_done    <= 1'b1;
            frame_changed <= differs;
            frame_err     <= 1'b0;
          end else begin
            frame_err <= 1'b1;
          end
          wait_cnt <= 32'(POLL_INTERVAL);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt <= 32'd1) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/led_display_poller.md
# led_display_poller

AXI read master that periodically scans the LED-display capture slave and keeps a clean, frame-consistent copy of the 32 digit segment bytes. It sits between the platform AXI interconnect (as a master) and the remote-lab status logic, which reads the snapshot through a simple random-access port. It raises a one-cycle frame-done strobe and a change flag, so upstream logic only forwards display updates when something differs.

## Interface
- POLL_INTERVAL, 50000: idle cycles from the end of one frame to the next AR issue (≥1).
- AXI_ID, 4'd0: constant ID driven on `MASTER_RD_ADDR_ID`.
- BASE_ADDR, 32'h0: word address of digit 0 in the slave.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- poll_en  in  1  enables starting new frames; sampled only in IDLE.
- MASTER_RD_ADDR_ID  out  4  = AXI_ID.
- MASTER_RD_ADDR  out  32  = BASE_ADDR.
- MASTER_RD_ADDR_LEN  out  8  burst length − 1 (31, or 37 with key capture).
- MASTER_RD_ADDR_BURST  out  2  2'b01 (INCR).
- MASTER_RD_ADDR_VALID  out  1  AR request.
- MASTER_RD_ADDR_READY  in  1  AR accept.
- MASTER_RD_BACK_ID  in  4  response ID; mismatch with AXI_ID counts as an error.
- MASTER_RD_DATA  in  32  beat data; [15:8] = digit index, [7:0] = segments.
- MASTER_RD_DATA_RESP  in  2  beat response.
- MASTER_RD_DATA_LAST  in  1  last beat.
- MASTER_RD_DATA_VALID  in  1  beat valid.
- MASTER_RD_DATA_READY  out  1  beat accept.
- snap_addr  in  5  digit index to read.
- snap_data  out  8  committed segment byte for snap_addr (combinational).
- frame_done  out  1  one-cycle pulse after a frame commits.
- frame_changed  out  1  valid with frame_done: committed frame differs from the previous one.
- frame_err  out  1  sticky; set by any bad frame, cleared when the next frame commits cleanly.

## Operation
- FSM: IDLE → ADDR → DATA → COMMIT → WAIT → IDLE.
- IDLE: when poll_en=1, go to ADDR.
- ADDR: ARVALID=1 and held stable until ARREADY. On the handshake go to DATA with beat counter = 0 and the frame error flag cleared.
- DATA: RREADY=1. On each beat with index < 32, the beat writes data[7:0] to `shadow[beat]`. The beat error flag is set if RESP≠0, BACK_ID≠AXI_ID, data[15:8]≠beat, or LAST is inconsistent with the counter (early or missing). The counter increments by 1 per beat and is 6 bits wide with no wrap. On LAST go to COMMIT.
- COMMIT (1 cycle):
  - If there is no error, copy shadow to snap, pulse frame_done, drive frame_changed = (shadow≠snap), and clear frame_err.
  - If there is an error, leave snap untouched, set frame_err, and do not pulse frame_done.
  - Either way, load the interval counter and go to WAIT.
- WAIT: count down POLL_INTERVAL cycles, then go to IDLE.
- poll_en dropping mid-frame does not abort; the burst always drains.
- rst mid-burst: FSM returns to IDLE, the beat is dropped, and the interconnect is reset together with this block.

## Timing
- Reset values: ARVALID=0, RREADY=0, frame_done=0, frame_changed=0, frame_err=0, snap all 8'h00, shadow all 8'h00.
- AR issues the cycle after IDLE sees poll_en=1.
- RREADY stays high for every DATA cycle, so there is no backpressure.
- frame_done rises exactly 1 cycle after the LAST handshake.
- snap changes only on the COMMIT edge, so snap_data is never a mix of two frames.
- Frame period = POLL_INTERVAL + AR latency + beats + 2 cycles.

## Configuration
- LED_DISPLAY_POLLER_KEY_EN:
  - Defined: LEN = 37, and beats 32..37 (key_ctrl, key_out[4:0]) latch bit 0 into a 6-bit `key_state` output, committed with snap. Those beats skip the index check.
  - Undefined: LEN = 31, and there is no key_state port.

## Structure
- Package `led_display_pkg`: digit count (32), key register count (6), address offsets, AXI burst/resp encodings, FSM state enum.
- One sub-module, `led_frame_buffer`: shadow plus snap arrays, the commit copy, the compare logic for frame_changed, and the read port.

## Test plan
- Clean frame: slave returns beat i = {16'd0, i, i^8'hA5}, with POLL_INTERVAL=4. Required: frame_done pulses once, frame_changed=1, snap_data(7)=8'hA2, frame_err=0.
- Identical second frame. Required: frame_done pulses, frame_changed=0.
- RESP=2'b10 on beat 10. Required: no frame_done, frame_err=1, snap unchanged; the next clean frame clears frame_err.
- Early LAST at beat 20. Required: frame_err=1, snap unchanged, FSM reaches WAIT.
- ARREADY delayed 5 cycles and poll_en dropped mid-burst. Required: ARVALID held stable, the burst completes, and no new AR issues while poll_en=0.
- rst asserted at beat 15. Required: ARVALID=0, RREADY=0, and snap is all zero in the same cycle.
